// File: rtl/reg_file_pkg.sv
// Shared register-file types: default widths, the writeback request record and
// the round-robin source selector used by wb_arbiter.
package reg_file_pkg;

    localparam int RF_ADDR_WIDTH = 3;
    localparam int RF_REG_WIDTH  = 32;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_REG_WIDTH-1:0]  val;
    } wb_req_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = reg_file_pkg::wb_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    T            mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter feeding the register file write port.
// Build option WB_ARB_ZERO_REG_EN: requests to register 0 are accepted and discarded.
module wb_arbiter #(
    parameter int ADDR_WIDTH = reg_file_pkg::RF_ADDR_WIDTH,
    parameter int REG_WIDTH  = reg_file_pkg::RF_REG_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [REG_WIDTH-1:0]  i_a_val,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [REG_WIDTH-1:0]  i_b_val,
    output logic [ADDR_WIDTH-1:0] o_reg_addr_w,
    output logic [REG_WIDTH-1:0]  o_reg_val_w,
    output logic                  o_write_en,
    output logic                  o_idle
);

    import reg_file_pkg::*;

    // rr_q  | meaning
    // SRC_A | A wins the next contended slot
    // SRC_B | B wins the next contended slot

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  val;
    } req_t;

    logic    a_push, a_pop, a_full, a_empty;
    logic    b_push, b_pop, b_full, b_empty;
    req_t    a_in, b_in, a_head, b_head;
    wb_src_e rr_q, rr_d;

    assign o_a_ready = !a_full;
    assign o_b_ready = !b_full;
    assign a_in      = '{addr: i_a_addr, val: i_a_val};
    assign b_in      = '{addr: i_b_addr, val: i_b_val};

`ifdef WB_ARB_ZERO_REG_EN
    assign a_push = i_a_valid && !a_full && (i_a_addr != '0);
    assign b_push = i_b_valid && !b_full && (i_b_addr != '0);
`else
    assign a_push = i_a_valid && !a_full;
    assign b_push = i_b_valid && !b_full;
`endif

    wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo_a (
        .clk(i_clk), .rst(i_rst), .push(a_push), .push_data(a_in),
        .pop(a_pop), .full(a_full), .empty(a_empty), .head(a_head)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo_b (
        .clk(i_clk), .rst(i_rst), .push(b_push), .push_data(b_in),
        .pop(b_pop), .full(b_full), .empty(b_empty), .head(b_head)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rr_q <= SRC_A;
        else       rr_q <= rr_d;
    end

    always_comb begin
        rr_d  = rr_q;
        a_pop = 1'b0;
        b_pop = 1'b0;
        if (!a_empty && !b_empty) begin
            if (rr_q == SRC_A) begin
                a_pop = 1'b1;
                rr_d  = SRC_B;
            end else begin
                b_pop = 1'b1;
                rr_d  = SRC_A;
            end
        end else if (!a_empty) begin
            a_pop = 1'b1;
        end else if (!b_empty) begin
            b_pop = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_write_en   <= 1'b0;
            o_reg_addr_w <= '0;
            o_reg_val_w  <= '0;
        end else begin
            o_write_en <= a_pop || b_pop;
            if (a_pop) begin
                o_reg_addr_w <= a_head.addr;
                o_reg_val_w  <= a_head.val;
            end else if (b_pop) begin
                o_reg_addr_w <= b_head.addr;
                o_reg_val_w  <= b_head.val;
            end
        end
    end

    assign o_idle = a_empty && b_empty && !o_write_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed pushes queue their hand-ordered
// expected writes; a monitor pops and compares on every o_write_en.
module tb_wb_arbiter;

    localparam int AW = 3;
    localparam int RW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_a_valid = 1'b0;
    logic          o_a_ready;
    logic [AW-1:0] i_a_addr = '0;
    logic [RW-1:0] i_a_val = '0;
    logic          i_b_valid = 1'b0;
    logic          o_b_ready;
    logic [AW-1:0] i_b_addr = '0;
    logic [RW-1:0] i_b_val = '0;
    logic [AW-1:0] o_reg_addr_w;
    logic [RW-1:0] o_reg_val_w;
    logic          o_write_en;
    logic          o_idle;

    wb_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_val(i_a_val),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_val(i_b_val),
        .o_reg_addr_w(o_reg_addr_w), .o_reg_val_w(o_reg_val_w),
        .o_write_en(o_write_en), .o_idle(o_idle)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] val;
    } wr_t;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            wr_cnt = 0;
    logic [RW-1:0] rf [8];

    // Register file model downstream of the write port.
    always @(posedge i_clk) begin
        if (!i_rst && o_write_en) rf[o_reg_addr_w] <= o_reg_val_w;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void expect_wr(input logic [AW-1:0] a, input logic [RW-1:0] v);
        wr_t e;
        e.addr = a;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_write_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d val 0x%0h, required no write",
                             o_reg_addr_w, o_reg_val_w);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 64'(o_reg_addr_w), 64'(e.addr));
                    check("write_val", 64'(o_reg_val_w), 64'(e.val));
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || !o_idle) && cyc < 64) begin
            @(negedge i_clk);
            #1;
            cyc++;
        end
        check(name, 64'(exp_q.size() == 0 && o_idle), 64'd1);
    endtask

    task automatic drive_a(input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
        i_a_valid = v;
        i_a_addr  = a;
        i_a_val   = d;
    endtask

    task automatic drive_b(input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
        i_b_valid = v;
        i_b_addr  = a;
        i_b_val   = d;
    endtask

    initial begin
        int base;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout, required end of test");
                $fatal(1, "watchdog");
            end
        join_none

        #1 i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check("rst_we", 64'(o_write_en), 64'd0);
        check("rst_addr", 64'(o_reg_addr_w), 64'd0);
        check("rst_val", 64'(o_reg_val_w), 64'd0);
        check("rst_idle", 64'(o_idle), 64'd1);
        check("rst_a_ready", 64'(o_a_ready), 64'd1);
        check("rst_b_ready", 64'(o_b_ready), 64'd1);
        i_rst = 1'b0;

        // Reset mid-operation: third entry is still buffered when reset hits.
        drive_a(1'b1, 3'd1, 32'h100);
        expect_wr(3'd1, 32'h100);
        @(negedge i_clk);
        drive_a(1'b1, 3'd2, 32'h101);
        expect_wr(3'd2, 32'h101);
        @(negedge i_clk);
        drive_a(1'b1, 3'd3, 32'h102);
        @(negedge i_clk);
        drive_a(1'b0, '0, '0);
        #1 i_rst = 1'b1;
        #1;
        check("midrst_we", 64'(o_write_en), 64'd0);
        check("midrst_idle", 64'(o_idle), 64'd1);
        check("midrst_addr", 64'(o_reg_addr_w), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (6) @(negedge i_clk);
        #1;
        check("postrst_idle", 64'(o_idle), 64'd1);
        check("postrst_queue", 64'(exp_q.size()), 64'd0);

        // Single push latency.
        do_reset();
        drive_a(1'b1, 3'd2, 32'd23);
        expect_wr(3'd2, 32'd23);
        @(negedge i_clk);
        check("lat_k_we", 64'(o_write_en), 64'd0);
        drive_a(1'b0, '0, '0);
        @(negedge i_clk);
        check("lat_k1_we", 64'(o_write_en), 64'd1);
        check("lat_k1_addr", 64'(o_reg_addr_w), 64'd2);
        check("lat_k1_val", 64'(o_reg_val_w), 64'd23);
        @(negedge i_clk);
        check("lat_rf2", 64'(rf[2]), 64'd23);
        wait_drain("lat_drain");

        // Both sources push every cycle: strict A,B alternation, one write per cycle.
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            check("alt_a_ready", 64'(o_a_ready), 64'd1);
            check("alt_b_ready", 64'(o_b_ready), 64'd1);
            drive_a(1'b1, AW'(1 + i), 32'h10 + 32'(i));
            drive_b(1'b1, AW'(7 - i), 32'h20 + 32'(i));
            expect_wr(AW'(1 + i), 32'h10 + 32'(i));
            expect_wr(AW'(7 - i), 32'h20 + 32'(i));
            @(negedge i_clk);
        end
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        repeat (5) @(negedge i_clk);
        #1;
        check("alt_tput_writes", 64'(wr_cnt - base), 64'd8);
        wait_drain("alt_drain");

        // B fills under contention; an attempt while full is ignored.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, AW'(1 + i), 32'h30 + 32'(i));
            drive_b(1'b1, AW'(7 - i), 32'h40 + 32'(i));
            expect_wr(AW'(1 + i), 32'h30 + 32'(i));
            expect_wr(AW'(7 - i), 32'h40 + 32'(i));
            @(negedge i_clk);
        end
        check("full_b_ready", 64'(o_b_ready), 64'd0);
        check("full_a_ready", 64'(o_a_ready), 64'd1);
        drive_a(1'b0, '0, '0);
        drive_b(1'b1, 3'd7, 32'hBAD);
        @(negedge i_clk);
        check("full_b_ready_after_pop", 64'(o_b_ready), 64'd1);
        drive_b(1'b0, '0, '0);
        wait_drain("full_drain");

        // Same destination from both sources: later grant (B) wins.
        do_reset();
        drive_a(1'b1, 3'd5, 32'h11);
        drive_b(1'b1, 3'd5, 32'h22);
        expect_wr(3'd5, 32'h11);
        expect_wr(3'd5, 32'h22);
        @(negedge i_clk);
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        wait_drain("same_reg_drain");
        @(negedge i_clk);
        check("same_reg_rf5", 64'(rf[5]), 64'h22);

        // Register 0 request.
        do_reset();
        check("zero_a_ready", 64'(o_a_ready), 64'd1);
        drive_a(1'b1, 3'd0, 32'hFF);
`ifndef WB_ARB_ZERO_REG_EN
        expect_wr(3'd0, 32'hFF);
`endif
        @(negedge i_clk);
        drive_a(1'b0, '0, '0);
`ifdef WB_ARB_ZERO_REG_EN
        check("zero_idle", 64'(o_idle), 64'd1);
`else
        check("zero_idle", 64'(o_idle), 64'd0);
`endif
        wait_drain("zero_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
